// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Operands are reduced to magnitudes on acceptance; the sign is reapplied once at the end.
module seq_mult_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   out_q, out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
                    mag_a_d = (is_signed && A[WIDTH-1]) ? -A : A;
                    mag_b_d = (is_signed && B[WIDTH-1]) ? -B : B;
                    neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + (PW'(mag_a_q) << cnt_q);
                end
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                out_d   = neg_q ? -acc_q : acc_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param at WIDTH 8 (directed), 16 and 4 (random vs reference multiply).
// Expected latency: done rises WIDTH+2 edges after the request, counting the accepting edge.
module tb_seq_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_L;

    logic        s8, sg8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    logic        s16, sg16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] out16;

    logic        s4, sg4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  out4;

    seq_mult_param #(.WIDTH(8)) u8 (
        .clk(clk), .reset_L(reset_L), .start(s8), .is_signed(sg8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .out(out8)
    );
    seq_mult_param #(.WIDTH(16)) u16 (
        .clk(clk), .reset_L(reset_L), .start(s16), .is_signed(sg16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .out(out16)
    );
    seq_mult_param #(.WIDTH(4)) u4 (
        .clk(clk), .reset_L(reset_L), .start(s4), .is_signed(sg4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .out(out4)
    );

    typedef struct {
        logic [31:0] prod;
        int          acc;
        string       tag;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q4[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: pop one expectation on each rising edge of done.
    logic d8p = 1'b0, d16p = 1'b0, d4p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done8 && !d8p) begin
            if (q8.size() == 0) chk("w8 unexpected_done", 64'(done8), 64'd0);
            else begin
                e = q8.pop_front();
                chk({e.tag, " out"}, 64'(out8), 64'(e.prod[15:0]));
                chk({e.tag, " latency"}, 64'(cyc - e.acc), 64'd9);
            end
        end
        d8p <= done8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done16 && !d16p) begin
            if (q16.size() == 0) chk("w16 unexpected_done", 64'(done16), 64'd0);
            else begin
                e = q16.pop_front();
                chk({e.tag, " out"}, 64'(out16), 64'(e.prod));
                chk({e.tag, " latency"}, 64'(cyc - e.acc), 64'd17);
            end
        end
        d16p <= done16;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4 && !d4p) begin
            if (q4.size() == 0) chk("w4 unexpected_done", 64'(done4), 64'd0);
            else begin
                e = q4.pop_front();
                chk({e.tag, " out"}, 64'(out4), 64'(e.prod[7:0]));
                chk({e.tag, " latency"}, 64'(cyc - e.acc), 64'd5);
            end
        end
        d4p <= done4;
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                          input logic [15:0] expv, input string tag);
        @(negedge clk);
        a8 = a; b8 = b; sg8 = sg; s8 = 1'b1;
        q8.push_back('{prod: 32'(expv), acc: cyc + 1, tag: tag});
    endtask

    // Waits for done, holds start `hold` extra cycles checking stability, then releases.
    task automatic finish8(input int hold, input logic [15:0] expv, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " done_seen"}, 64'(ok), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_done"}, 64'(done8), 64'd1);
            chk({tag, " hold_out"}, 64'(out8), 64'(expv));
        end
        s8 = 1'b0;
        @(negedge clk);
        chk({tag, " done_drop"}, 64'(done8), 64'd0);
        chk({tag, " out_kept"}, 64'(out8), 64'(expv));
    endtask

    task automatic run16(input int n);
        logic [15:0] ra, rb;
        logic        sg;
        longint      ea, eb, p;
        bit          ok;
        for (int i = 0; i < n; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            sg = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 16'h8000; rb = 16'h8000; sg = 1'b1; end
            ea = sg ? longint'($signed(ra)) : longint'(ra);
            eb = sg ? longint'($signed(rb)) : longint'(rb);
            p  = ea * eb;
            @(negedge clk);
            a16 = ra; b16 = rb; sg16 = sg; s16 = 1'b1;
            q16.push_back('{prod: p[31:0], acc: cyc + 1, tag: $sformatf("w16 op%0d", i)});
            ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (done16) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk($sformatf("w16 op%0d done_seen", i), 64'(ok), 64'd1);
            s16 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run4(input int n);
        logic [3:0] ra, rb;
        logic       sg;
        longint     ea, eb, p;
        bit         ok;
        for (int i = 0; i < n; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            sg = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 4'h8; rb = 4'h8; sg = 1'b1; end
            ea = sg ? longint'($signed(ra)) : longint'(ra);
            eb = sg ? longint'($signed(rb)) : longint'(rb);
            p  = ea * eb;
            @(negedge clk);
            a4 = ra; b4 = rb; sg4 = sg; s4 = 1'b1;
            q4.push_back('{prod: 32'(p[7:0]), acc: cyc + 1, tag: $sformatf("w4 op%0d", i)});
            ok = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done4) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk($sformatf("w4 op%0d done_seen", i), 64'(ok), 64'd1);
            s4 = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L = 1'b0;
        s8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        s16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        s4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset done8", 64'(done8), 64'd0);
        chk("reset out8", 64'(out8), 64'd0);
        chk("reset out16", 64'(out16), 64'd0);
        chk("reset out4", 64'(out4), 64'd0);
        reset_L = 1'b1;

        issue8(8'h80, 8'hFF, 1'b1, 16'h0080, "s_m128_x_m1");
        finish8(0, 16'h0080, "s_m128_x_m1");
        issue8(8'h80, 8'hFF, 1'b0, 16'h7F80, "u_80_x_FF");
        finish8(0, 16'h7F80, "u_80_x_FF");
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_FF_x_FF");
        finish8(0, 16'hFE01, "u_FF_x_FF");
        issue8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_sq");
        finish8(0, 16'h4000, "s_m128_sq");
        issue8(8'h03, 8'hFB, 1'b1, 16'hFFF1, "s_3_x_m5");
        finish8(0, 16'hFFF1, "s_3_x_m5");
        issue8(8'h00, 8'hFB, 1'b1, 16'h0000, "s_0_x_m5");
        finish8(0, 16'h0000, "s_0_x_m5");
        issue8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_127_x_m128");
        finish8(0, 16'hC080, "s_127_x_m128");

        // Hold past done, and disturb operands mid-calculation.
        issue8(8'h05, 8'h07, 1'b0, 16'h0023, "u_5_x_7");
        @(negedge clk);
        chk("u_5_x_7 busy", 64'(busy8), 64'd1);
        chk("u_5_x_7 not_done", 64'(done8), 64'd0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sg8 = 1'b1;
        finish8(5, 16'h0023, "u_5_x_7");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sg8 = 1'b0; s8 = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        reset_L = 1'b0;
        s8 = 1'b0;
        #1;
        chk("async_rst busy8", 64'(busy8), 64'd0);
        chk("async_rst done8", 64'(done8), 64'd0);
        chk("async_rst out8", 64'(out8), 64'd0);
        @(negedge clk);
        reset_L = 1'b1;
        issue8(8'hF6, 8'h0C, 1'b1, 16'hFF88, "post_rst_m10_x_12");
        finish8(0, 16'hFF88, "post_rst_m10_x_12");

        run16(200);
        run4(200);

        repeat (3) @(negedge clk);
        chk("q8 drained", 64'(q8.size()), 64'd0);
        chk("q16 drained", 64'(q16.size()), 64'd0);
        chk("q4 drained", 64'(q4.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
